stream_width_downsizer: RTL

- Valid/ready serializer that sits directly downstream of skid_buffer and consumes its WIDTH-bit word stream.
- Each accepted word is split into RATIO = IN_WIDTH/OUT_WIDTH narrower beats, driven out in order under its own valid/ready handshake.
- A word-level last flag is carried through to the final beat of the word.
- Full throughput: one output beat per cycle, with no bubble between consecutive words.

---
 rtl/stream_pkg.sv | 28 ++
 rtl/stream_width_downsizer.sv | 88 ++++++++
 2 files changed

// File: rtl/stream_pkg.sv
// Shared stream-path definitions: default widths and
// helpers for width ratio and beat-counter sizing.
package stream_pkg;

    localparam int STREAM_W = 32;
    localparam int BYTE_W   = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } dsz_state_e;

    // Beats per word; guards against a zero output width.
    function automatic int ratio_of(input int in_w, input int out_w);
        return (out_w > 0) ? (in_w / out_w) : 0;
    endfunction

    // True when in_w splits into an integral number (>= 2) of beats.
    function automatic bit ratio_ok(input int in_w, input int out_w);
        return (out_w > 0) && ((in_w % out_w) == 0) &&
               ((in_w / out_w) >= 2);
    endfunction

    function automatic int cnt_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/stream_width_downsizer.sv
// Serializes IN_WIDTH-bit words into RATIO OUT_WIDTH-bit beats.
// Ports: clk, rst_n (sync, active-low); upstream in_valid/in_ready/
// in_data/in_last; downstream out_valid/out_ready/out_data/out_last.
module stream_width_downsizer
    import stream_pkg::*;
#(
    parameter int IN_WIDTH  = STREAM_W,
    parameter int OUT_WIDTH = BYTE_W,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last
);

    localparam int RATIO = ratio_of(IN_WIDTH, OUT_WIDTH);
    localparam int CW    = cnt_width(RATIO);
    localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

    generate
        if (!ratio_ok(IN_WIDTH, OUT_WIDTH)) begin : g_bad_ratio
            $error("IN_WIDTH must be a multiple >= 2 of OUT_WIDTH");
        end
    endgenerate

    dsz_state_e                  state_q;
    logic [CW-1:0]               cnt_q;
    logic [IN_WIDTH-1:0]         hold_q;
    logic                        last_q;

    logic [RATIO-1:0][OUT_WIDTH-1:0] slices;
    logic [CW-1:0]               sel;
    logic                        busy;
    logic                        at_last;
    logic                        in_fire;
    logic                        out_fire;

    assign busy     = (state_q == SEND);
    assign at_last  = (cnt_q == LAST_IDX);
    assign slices   = hold_q;

    // A new word may load in the same cycle the final beat leaves.
    assign in_ready = rst_n & (~busy | (out_ready & at_last));
    assign in_fire  = in_valid & in_ready;
    assign out_fire = busy & out_ready;

    generate
        if (MSB_FIRST) begin : g_msb
            assign sel = LAST_IDX - cnt_q;
        end else begin : g_lsb
            assign sel = cnt_q;
        end
    endgenerate

    assign out_valid = busy;
    assign out_data  = slices[sel];
    assign out_last  = busy & last_q & at_last;

    // in_fire while SEND can only occur on the final accepted beat,
    // so a load covers both the IDLE start and the seamless reload.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            last_q  <= 1'b0;
        end else if (in_fire) begin
            state_q <= SEND;
            cnt_q   <= '0;
            hold_q  <= in_data;
            last_q  <= in_last;
        end else if (out_fire) begin
            if (at_last) begin
                state_q <= IDLE;
            end else begin
                cnt_q   <= cnt_q + 1'b1;
            end
        end
    end

endmodule
